// File: rtl/scaled_scroll_tile_mapper.sv
// Background mapper: scales a SRC_W x SRC_H indexed image onto the screen with
// frame-latched scroll wrap, optional mirror, and a 3-cycle aligned colour pipeline.
module scaled_scroll_tile_mapper #(
    parameter int unsigned SRC_W    = 96,
    parameter int unsigned SRC_H    = 96,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned IDX_W    = 4
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        scroll_x,
    input  logic [9:0]        scroll_y,
    input  logic              mirror_x,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        palette_red,
    input  logic [3:0]        palette_green,
    input  logic [3:0]        palette_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
);

    localparam int unsigned CW  = 10;
    localparam int unsigned SW  = CW + 1;
    localparam int unsigned AXW = $clog2(SCREEN_W) + 1;
    localparam int unsigned AYW = $clog2(SCREEN_H) + 1;

    localparam logic [CW-1:0] SRC_W_C = CW'(SRC_W);
    localparam logic [CW-1:0] SRC_H_C = CW'(SRC_H);

    logic [AXW-1:0]    ax_q, ax_d, ax_step;
    logic [AYW-1:0]    ay_q, ay_d, ay_step;
    logic [CW-1:0]     sx_q, sx_d, sy_q, sy_d;
    logic [CW-1:0]     prev_x_q, prev_y_q;
    logic [CW-1:0]     scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
    logic              mirror_q, mirror_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              blank_q1, blank_q2;
    logic [3:0]        red_q, green_q, blue_q;

    logic          x_in, y_in, frame_start;
    logic [CW-1:0] mx, px, py;
    logic [SW-1:0] px_sum, py_sum;

    assign x_in        = DrawX < CW'(SCREEN_W);
    assign y_in        = DrawY < CW'(SCREEN_H);
    assign frame_start = (DrawX == '0) && (DrawY == '0);
    assign ax_step     = ax_q + AXW'(SRC_W);
    assign ay_step     = ay_q + AYW'(SRC_H);

    // Step accumulators, frame latch and wrapped source address for this pixel
    always_comb begin
        ax_d          = ax_q;
        sx_d          = sx_q;
        ay_d          = ay_q;
        sy_d          = sy_q;
        scroll_x_d    = scroll_x_q;
        scroll_y_d    = scroll_y_q;
        mirror_d      = mirror_q;
        rom_address_d = rom_address_q;

        if (DrawX == '0) begin
            ax_d = '0;
            sx_d = '0;
        end else if (x_in && (DrawX != prev_x_q)) begin
            if (ax_step >= AXW'(SCREEN_W)) begin
                ax_d = ax_step - AXW'(SCREEN_W);
                sx_d = sx_q + CW'(1);
            end else begin
                ax_d = ax_step;
            end
        end

        if (DrawY == '0) begin
            ay_d = '0;
            sy_d = '0;
        end else if (y_in && (DrawY != prev_y_q)) begin
            if (ay_step >= AYW'(SCREEN_H)) begin
                ay_d = ay_step - AYW'(SCREEN_H);
                sy_d = sy_q + CW'(1);
            end else begin
                ay_d = ay_step;
            end
        end

        // New frame values apply to the very first pixel of the frame
        if (frame_start) begin
            scroll_x_d = CW'(scroll_x % SRC_W_C);
            scroll_y_d = CW'(scroll_y % SRC_H_C);
            mirror_d   = mirror_x;
        end

        mx     = mirror_d ? (SRC_W_C - CW'(1) - sx_d) : sx_d;
        px_sum = SW'(mx) + SW'(scroll_x_d);
        py_sum = SW'(sy_d) + SW'(scroll_y_d);
        px     = (px_sum >= SW'(SRC_W)) ? CW'(px_sum - SW'(SRC_W)) : CW'(px_sum);
        py     = (py_sum >= SW'(SRC_H)) ? CW'(py_sum - SW'(SRC_H)) : CW'(py_sum);

        if (x_in && y_in) begin
            rom_address_d = ADDR_W'(py) * ADDR_W'(SRC_W) + ADDR_W'(px);
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ax_q          <= '0;
            sx_q          <= '0;
            ay_q          <= '0;
            sy_q          <= '0;
            prev_x_q      <= '0;
            prev_y_q      <= '0;
            scroll_x_q    <= '0;
            scroll_y_q    <= '0;
            mirror_q      <= 1'b0;
            rom_address_q <= '0;
            blank_q1      <= 1'b0;
            blank_q2      <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            ax_q          <= ax_d;
            sx_q          <= sx_d;
            ay_q          <= ay_d;
            sy_q          <= sy_d;
            prev_x_q      <= DrawX;
            prev_y_q      <= DrawY;
            scroll_x_q    <= scroll_x_d;
            scroll_y_q    <= scroll_y_d;
            mirror_q      <= mirror_d;
            rom_address_q <= rom_address_d;
            blank_q1      <= blank;
            blank_q2      <= blank_q1;
            // Third stage: colour register gated by blank aligned with rom_q
            red_q         <= blank_q2 ? palette_red   : 4'h0;
            green_q       <= blank_q2 ? palette_green : 4'h0;
            blue_q        <= blank_q2 ? palette_blue  : 4'h0;
        end
    end

    assign rom_address = rom_address_q;
    assign pal_index   = rom_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: tb/tb_scaled_scroll_tile_mapper.sv
// Directed bench for scaled_scroll_tile_mapper: scaling, scroll wrap, mirror,
// out-of-range hold, blank alignment and asynchronous reset.
module tb_scaled_scroll_tile_mapper;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, scroll_x, scroll_y;
    logic        blank, mirror_x;
    logic [14:0] rom_address;
    logic [3:0]  rom_q, pal_index;
    logic [3:0]  palette_red, palette_green, palette_blue;
    logic [3:0]  red, green, blue;

    int n_cmp = 0;
    int n_err = 0;

    always #5 vga_clk = ~vga_clk;

    // External ROM with 1-cycle read latency; data = low address bits
    always @(posedge vga_clk) rom_q <= rom_address[3:0];

    scaled_scroll_tile_mapper dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank        (blank),
        .scroll_x     (scroll_x),
        .scroll_y     (scroll_y),
        .mirror_x     (mirror_x),
        .rom_address  (rom_address),
        .rom_q        (rom_q),
        .pal_index    (pal_index),
        .palette_red  (palette_red),
        .palette_green(palette_green),
        .palette_blue (palette_blue),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_xy(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
    endtask

    initial begin
        reset_n       = 1'b0;
        DrawX         = '0;
        DrawY         = '0;
        scroll_x      = '0;
        scroll_y      = '0;
        mirror_x      = 1'b0;
        blank         = 1'b1;
        palette_red   = 4'hF;
        palette_green = 4'h5;
        palette_blue  = 4'hA;
        tick();
        tick();
        chk("reset_addr", 32'(rom_address), 0);
        chk("reset_red", 32'(red), 0);
        chk("reset_green", 32'(green), 0);
        chk("reset_blue", 32'(blue), 0);
        reset_n = 1'b1;

        // Line sweep on row 0, no scroll
        for (int x = 0; x < 640; x++) begin
            set_xy(x, 0);
            if (x == 0)   chk("line_x0", 32'(rom_address), 0);
            if (x == 10)  chk("line_x10", 32'(rom_address), 1);
            if (x == 100) chk("line_x100", 32'(rom_address), 15);
            if (x == 639) chk("line_x639", 32'(rom_address), 95);
        end
        chk("active_red", 32'(red), 15);
        chk("active_green", 32'(green), 5);
        chk("active_blue", 32'(blue), 10);

        // Walk to the bottom-right pixel
        for (int y = 0; y < 480; y++) set_xy(0, y);
        for (int x = 1; x < 640; x++) set_xy(x, 479);
        chk("corner", 32'(rom_address), 9215);
        for (int i = 0; i < 5; i++) begin
            set_xy(639, 479);
            chk("corner_hold", 32'(rom_address), 9215);
        end
        set_xy(700, 479);
        chk("oor_x_hold", 32'(rom_address), 9215);
        set_xy(639, 600);
        chk("oor_y_hold", 32'(rom_address), 9215);

        // Scroll latched at frame start, ignored mid-frame
        scroll_x = 10'd90;
        scroll_y = 10'd200;
        set_xy(0, 0);
        chk("scroll_origin", 32'(rom_address), 858);
        for (int x = 1; x <= 100; x++) set_xy(x, 0);
        chk("scroll_x100", 32'(rom_address), 777);
        scroll_x = 10'd0;
        scroll_y = 10'd0;
        for (int x = 101; x <= 110; x++) set_xy(x, 0);
        chk("scroll_midframe", 32'(rom_address), 778);
        set_xy(0, 0);
        chk("scroll_next_frame", 32'(rom_address), 0);

        // Mirror latched at frame start
        mirror_x = 1'b1;
        set_xy(0, 0);
        chk("mirror_x0", 32'(rom_address), 95);
        set_xy(0, 0);
        chk("pal_index", 32'(pal_index), 15);
        mirror_x = 1'b0;
        for (int x = 1; x < 640; x++) begin
            set_xy(x, 0);
            if (x == 100) chk("mirror_x100", 32'(rom_address), 80);
        end
        chk("mirror_x639", 32'(rom_address), 0);

        // One-cycle blank gap appears 3 cycles later
        blank = 1'b0;
        tick();
        blank = 1'b1;
        tick();
        chk("blank_n2", 32'(red), 15);
        tick();
        chk("blank_n3_red", 32'(red), 0);
        chk("blank_n3_green", 32'(green), 0);
        tick();
        chk("blank_n4_red", 32'(red), 15);

        // Asynchronous reset mid-line
        set_xy(300, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_addr", 32'(rom_address), 0);
        chk("midreset_red", 32'(red), 0);
        DrawX = '0;
        DrawY = '0;
        #1 reset_n = 1'b1;
        tick();
        tick();
        chk("rel_n2_red", 32'(red), 0);
        tick();
        chk("rel_n3_red", 32'(red), 15);
        for (int x = 1; x <= 10; x++) set_xy(x, 0);
        chk("rel_x10", 32'(rom_address), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scaled_scroll_tile_mapper.md
Name: scaled_scroll_tile_mapper

Overview:
- Parametrised next-generation background mapper for the VGA pipeline.
- Maps the screen pixel (DrawX, DrawY) to an address in a SRC_W x SRC_H indexed-colour ROM, with nearest-neighbour scaling to the screen.
- Uses incremental step accumulators instead of multiply/divide.
- Adds frame-latched X/Y scroll with wrap-around, optional horizontal mirror, and a fixed 3-cycle pipeline with aligned blanking.
- The ROM and palette are instantiated outside the block and connect through ports, so one mapper serves any level background.

Parameters:
SRC_W, 96, source image width in pixels (1..SCREEN_W)
SRC_H, 96, source image height in pixels (1..SCREEN_H)
SCREEN_W, 640, active screen width
SCREEN_H, 480, active screen height
ADDR_W, 15, ROM address width (2^ADDR_W >= SRC_W*SRC_H)
IDX_W, 4, palette index width

Ports:
vga_clk  in  1  pixel clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
DrawX  in  10  current screen column
DrawY  in  10  current screen row
blank  in  1  1 = active video (same polarity as the existing mappers)
scroll_x  in  10  horizontal source offset in source pixels
scroll_y  in  10  vertical source offset in source pixels
mirror_x  in  1  1 = horizontally mirror the source
rom_address  out  ADDR_W  registered address to the external ROM (1-cycle read latency)
rom_q  in  IDX_W  ROM data
pal_index  out  IDX_W  rom_q forwarded combinationally to the external palette
palette_red, palette_green, palette_blue  in  4 each  palette output
red, green, blue  out  4 each  registered pixel colour

Behaviour:
- Reset (reset_n=0, asynchronous):
  - rom_address=0; red/green/blue=0.
  - Blank pipeline cleared to 0.
  - X/Y accumulators, latched scroll values and latched mirror value = 0.
- Scaling, X direction:
  - Accumulator ax (width >= clog2(SCREEN_W)+1) and counter sx.
  - DrawX==0: ax=0, sx=0.
  - Each cycle DrawX differs from its previous sampled value: ax+=SRC_W; if ax>=SCREEN_W then ax-=SCREEN_W and sx+=1.
  - With DrawX incrementing by 1 from 0, sx = floor(DrawX*SRC_W/SCREEN_W) exactly.
  - DrawX unchanged from its previous value: hold ax and sx.
- Scaling, Y direction:
  - Same scheme with ay/sy, stepped by SRC_H against SCREEN_H.
  - Y steps only when DrawY changes; DrawY==0 clears ay and sy.
- Frame latch:
  - When DrawX==0 and DrawY==0, capture scroll_x mod SRC_W, scroll_y mod SRC_H and mirror_x.
  - Captured values hold for the entire frame; changes to scroll_x/scroll_y/mirror_x mid-frame have no effect until the next frame start.
- Wrap-around:
  - mx = mirror ? (SRC_W-1-sx) : sx.
  - px = mx+scroll_x_l; if px>=SRC_W then px-=SRC_W.
  - py = sy+scroll_y_l; if py>=SRC_H then py-=SRC_H.
  - Single conditional subtract only; no modulo operator.
- Pipeline:
  - Cycle N: DrawX/DrawY sampled.
  - N+1: rom_address = py*SRC_W + px, registered.
  - N+2: rom_q valid.
  - N+3: red/green/blue registered.
  - Total latency = 3 cycles.
- Blanking:
  - blank is delayed by the same 3 stages.
  - Delayed blank=1: output palette_*; delayed blank=0: output 0.
  - rom_address keeps updating during blanking.
- Out-of-range draw coordinates:
  - DrawX>=SCREEN_W or DrawY>=SCREEN_H: accumulators hold (no step).
  - rom_address is clamped to its last valid value, so it never exceeds SRC_W*SRC_H-1.
- Reset mid-frame:
  - All state clears immediately.
  - Output addresses are valid again from the next DrawX==0; the full scroll state is restored at the next frame start.

Test Plan:
- Reset asserted mid-line with blank=1 -> red/green/blue=0 and rom_address=0 the same cycle; after release, outputs track the new pixels 3 cycles later.
- Full line sweep DrawX 0..639, DrawY=0, no scroll -> rom_address at DrawX=10 is 1, at 100 is 15, at 639 is 95; each appears 1 cycle after its DrawX.
- DrawY=479, DrawX=639, no scroll -> rom_address=9215; DrawX held at 639 for 5 cycles -> address stays 9215.
- scroll_x=90, scroll_y=200 latched at frame start, DrawX=100, DrawY=0 -> px=(15+90)-96=9, py=200 mod 96=8, rom_address=8*96+9=777; scroll_x changed to 0 mid-frame -> address unchanged until the next frame.
- mirror_x=1 latched, no scroll, DrawX=0 -> px=95; DrawX=639 -> px=0.
- blank=0 at cycle N with palette_red=F -> red=0 at N+3; blank returns to 1 at N+1 -> red=F at N+4.
